morphle_config_loader: RTL and testbench
========================================

Name: morphle_config_loader

Overview:
Wishbone-slave sequencer that loads the configuration chain of a Morphle Logic yblock, replacing manual bit-banging of confclk/cbitin over logic-analyzer pins. Software pushes 16-bit column words into a small FIFO. The loader presents each word on cbitin, generates one confclk strobe with programmable low/high widths, and captures cbitout for readback. It also owns the block reset line. It sits between the user-project Wishbone port and the yblock configuration pins.

Parameters:
BLOCKWIDTH, 16, columns in the yblock, which is also the width of cbitin/cbitout; fixed at 16.
FIFO_DEPTH, 4, entries in the column-word FIFO; power of two, at least 2.
LOW_CYC, 2, clock cycles that confclk stays low with cbitin stable before each rising edge; at least 1.
HIGH_CYC, 2, clock cycles that confclk stays high; at least 1.

Ports:
wb_clk_i  in  1  single clock for the whole block.
wb_rst_ni  in  1  reset; synchronous, active-low.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  Wishbone write enable.
wbs_sel_i  in  4  byte selects; apply to CTRL and COUNT only.
wbs_dat_i  in  32  write data.
wbs_adr_i  in  32  address; bits [3:2] select the register.
wbs_ack_o  out  1  Wishbone acknowledge.
wbs_dat_o  out  32  read data.
blk_reset_o  out  1  yblock reset (freeze and clear).
confclk_o  out  1  configuration strobe to the yblock.
cbitin_o  out  16  configuration bits, one per column.
cbitout_i  in  16  configuration bits shifted out of the bottom of the block.
irq_o  out  1  level interrupt; equals done & irq_en.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge) sets the following:
  - wbs_ack_o=0, wbs_dat_o=0, confclk_o=0, cbitin_o=0, irq_o=0.
  - blk_reset_o=1, so the block stays frozen after reset.
  - FIFO empty, COUNT=0, readback=0, all sticky flags 0, state IDLE.
- Reset asserted mid-load aborts the load the same cycle. confclk_o must never be left high.
- Wishbone:
  - wbs_ack_o <= valid & !wbs_ack_o, where valid = wbs_cyc_i & wbs_stb_i.
  - Writes commit on the edge that raises ack. Reads return registered data with ack. No wait states.
- Register map (adr[3:2]):
  - 0 CTRL (RW): bit0 blk_reset, bit4 irq_en.
  - 0 CTRL (write-1 pulses): bit1 start, bit2 abort, bit3 clr_flags.
  - 1 STATUS (RO): bit0 busy, bit1 fifo_full, bit2 fifo_empty, bit3 done, bit4 overflow, bit5 starved, bits[10:8] fifo level.
  - 2 DATA: a write pushes wbs_dat_i[15:0]. A read returns the last captured cbitout in [15:0].
  - 3 COUNT (RW while IDLE): strobes remaining, [15:0]. Writes while busy are ignored.
- FIFO rules:
  - A DATA write when full is dropped and sets overflow (sticky).
  - A push and a pop in the same cycle are both honoured.
- Start rules:
  - start is ignored if busy, if COUNT=0, or if blk_reset=1.
  - Otherwise the block enters LOAD and clears done.
- State machine:
  - IDLE: confclk_o=0. On an accepted start, go to WAIT.
  - WAIT: if the FIFO is empty, stay and set starved (sticky). Otherwise load cbitin_o from the FIFO head and go to SETUP.
  - SETUP: confclk_o=0 for LOW_CYC cycles, then go to HIGH.
  - HIGH: confclk_o=1 for HIGH_CYC cycles. On the last HIGH cycle:
    - pop the FIFO;
    - capture cbitout_i into readback;
    - decrement COUNT.
  - After the last HIGH cycle: if COUNT is now 0, set done and go to IDLE; otherwise go to WAIT.
- Timing guarantees:
  - confclk_o is registered and glitch-free.
  - cbitin_o changes only while confclk_o=0, and is stable for at least LOW_CYC cycles before the rising edge.
  - cbitin_o holds its value after a load completes.
  - Back-to-back strobe period with the FIFO non-empty is 1 + LOW_CYC + HIGH_CYC cycles.
- Abort (any state): go to IDLE next cycle, confclk_o=0, FIFO flushed, COUNT=0. done is not set; readback is kept.
- clr_flags clears done, overflow and starved. If the same write also sets a flag event, the set wins.
- blk_reset may be written at any time and drives blk_reset_o directly from the CTRL register.

Decomposition:
- Shared package (morphle_pkg) holds:
  - register address constants;
  - CTRL/STATUS bit indices;
  - state encoding: IDLE, WAIT, SETUP, HIGH.
- One natural sub-module: morphle_cfg_fifo, a synchronous FIFO that is BLOCKWIDTH wide and FIFO_DEPTH deep, with full, empty and level outputs.
- The width counters (LOW_CYC/HIGH_CYC) stay inline.

Test Plan:
1. Reset, then read STATUS and CTRL -> STATUS=0x004 (fifo_empty), CTRL bit0=1, confclk_o=0, cbitin_o=0, irq_o=0.
2. CTRL=0x10 (release block reset, irq_en=1), COUNT=3, push 0xA5A5, 0x5A5A, 0xFFFF, then start -> exactly 3 confclk pulses, each 2 cycles high with cbitin stable at least 2 cycles before each rise; done=1, irq_o=1, COUNT=0, FIFO empty.
3. Push 5 words with FIFO_DEPTH=4 while IDLE -> 5th word dropped, overflow=1, level=4; clr_flags -> overflow=0.
4. COUNT=2, push one word, start -> one pulse, then the block stays in WAIT with confclk_o=0 and starved=1. Push 0x0001 -> second pulse; done=1.
5. Drive cbitout_i=0x1234 during a strobe -> a DATA read after the pulse returns 0x00001234.
6. Abort during HIGH, and separately deassert wb_rst_ni during HIGH -> confclk_o=0 the next cycle, busy=0, FIFO empty, COUNT=0, done=0.
7. With CTRL bit0=1, write start -> no pulse, busy=0.

Source files
------------

// File: rtl/morphle_pkg.sv
// Shared definitions for the Morphle yblock configuration loader.
// Holds the Wishbone register addresses (adr[3:2]), CTRL/STATUS bit indices
// and the sequencer state encoding.
package morphle_pkg;

    // Register addresses, decoded from wbs_adr_i[3:2]
    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_DATA   = 2'd2;
    localparam logic [1:0] ADR_COUNT  = 2'd3;

    // CTRL bits: blk_reset/irq_en are stored, start/abort/clr_flags are pulses
    localparam int CTRL_BLK_RESET = 0;
    localparam int CTRL_START     = 1;
    localparam int CTRL_ABORT     = 2;
    localparam int CTRL_CLR       = 3;
    localparam int CTRL_IRQ_EN    = 4;

    // STATUS bits
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_DONE    = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_STARVED = 5;
    localparam int ST_LVL_LSB = 8;

    // Sequencer states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SETUP = 2'd2;
    localparam logic [1:0] S_HIGH  = 2'd3;

endpackage

// File: rtl/morphle_cfg_fifo.sv
// Synchronous column-word FIFO for the configuration loader.
// Ports:
//   i_clk, i_rst_n   clock and synchronous active-low reset
//   i_flush          empties the FIFO (wins over push/pop)
//   i_push, i_wdata  write one word; ignored when full
//   i_pop            drop the head word; ignored when empty
//   o_rdata          current head word (first-word fall-through)
//   o_full, o_empty, o_level  occupancy
module morphle_cfg_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/morphle_config_loader.sv
// Wishbone-slave sequencer that loads the configuration chain of a Morphle
// yblock. Software queues 16-bit column words; each word is presented on
// cbitin_o, followed by one confclk_o strobe (LOW_CYC low, HIGH_CYC high),
// and cbitout_i is captured for readback. CTRL bit0 drives blk_reset_o.
// Ports:
//   wb_clk_i, wb_rst_ni          clock, synchronous active-low reset
//   wbs_*                        Wishbone slave (single-cycle ack, no wait states)
//   blk_reset_o, confclk_o       yblock reset and configuration strobe
//   cbitin_o, cbitout_i          configuration column data in/out
//   irq_o                        level interrupt = done & irq_en
module morphle_config_loader
    import morphle_pkg::*;
#(
    parameter int BLOCKWIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_CYC    = 2,
    parameter int HIGH_CYC   = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  blk_reset_o,
    output logic                  confclk_o,
    output logic [BLOCKWIDTH-1:0] cbitin_o,
    input  logic [BLOCKWIDTH-1:0] cbitout_i,
    output logic                  irq_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] LOW_LAST  = 8'(LOW_CYC - 1);
    localparam logic [7:0] HIGH_LAST = 8'(HIGH_CYC - 1);

    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  r_blk_reset;
    logic                  r_irq_en;
    logic                  r_done;
    logic                  r_ovf;
    logic                  r_starved;
    logic [15:0]           r_count;
    logic [BLOCKWIDTH-1:0] r_readback;
    logic [BLOCKWIDTH-1:0] r_cbitin;
    logic                  r_confclk;
    logic [1:0]            r_state;
    logic [7:0]            r_width_cnt;

    logic                  w_valid, w_acc, w_wr, w_rd;
    logic [1:0]            w_reg;
    logic                  w_ctrl_wr, w_start, w_abort, w_clr, w_start_ok;
    logic                  w_push, w_pop, w_count_wr, w_busy, w_high_last;
    logic [BLOCKWIDTH-1:0] w_fifo_head;
    logic                  w_fifo_full, w_fifo_empty;
    logic [LVL_W-1:0]      w_fifo_level;
    logic [31:0]           w_status;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

    // A transfer is accepted on the edge that raises ack.
    assign w_valid = wbs_cyc_i & wbs_stb_i;
    assign w_acc   = w_valid & ~r_ack;
    assign w_wr    = w_acc & wbs_we_i;
    assign w_rd    = w_acc & ~wbs_we_i;
    assign w_reg   = wbs_adr_i[3:2];

    assign w_busy      = (r_state != S_IDLE);
    assign w_ctrl_wr   = w_wr & (w_reg == ADR_CTRL) & wbs_sel_i[0];
    assign w_start     = w_ctrl_wr & wbs_dat_i[CTRL_START];
    assign w_abort     = w_ctrl_wr & wbs_dat_i[CTRL_ABORT];
    assign w_clr       = w_ctrl_wr & wbs_dat_i[CTRL_CLR];
    assign w_start_ok  = w_start & ~w_busy & (r_count != 16'd0) & ~r_blk_reset;
    assign w_push      = w_wr & (w_reg == ADR_DATA);
    assign w_count_wr  = w_wr & (w_reg == ADR_COUNT) & ~w_busy;
    assign w_high_last = (r_state == S_HIGH) && (r_width_cnt == HIGH_LAST);
    assign w_pop       = w_high_last & ~w_abort;

    morphle_cfg_fifo #(
        .WIDTH (BLOCKWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_wdata (wbs_dat_i[BLOCKWIDTH-1:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    always_comb begin
        w_status                            = '0;
        w_status[ST_BUSY]                   = w_busy;
        w_status[ST_FULL]                   = w_fifo_full;
        w_status[ST_EMPTY]                  = w_fifo_empty;
        w_status[ST_DONE]                   = r_done;
        w_status[ST_OVF]                    = r_ovf;
        w_status[ST_STARVED]                = r_starved;
        w_status[ST_LVL_LSB +: LVL_W]       = w_fifo_level;
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            ADR_CTRL: begin
                w_rdata[CTRL_BLK_RESET] = r_blk_reset;
                w_rdata[CTRL_IRQ_EN]    = r_irq_en;
            end
            ADR_STATUS: w_rdata = w_status;
            ADR_DATA:   w_rdata[BLOCKWIDTH-1:0] = r_readback;
            default:    w_rdata[15:0] = r_count;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_blk_reset <= 1'b1;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_starved   <= 1'b0;
            r_count     <= '0;
            r_readback  <= '0;
            r_cbitin    <= '0;
            r_confclk   <= 1'b0;
            r_state     <= S_IDLE;
            r_width_cnt <= '0;
        end else begin
            r_ack <= w_valid & ~r_ack;
            if (w_rd)
                r_dat <= w_rdata;
            if (w_ctrl_wr) begin
                r_blk_reset <= wbs_dat_i[CTRL_BLK_RESET];
                r_irq_en    <= wbs_dat_i[CTRL_IRQ_EN];
            end
            // Flag clear comes first so a same-cycle set event below wins.
            if (w_clr) begin
                r_done    <= 1'b0;
                r_ovf     <= 1'b0;
                r_starved <= 1'b0;
            end
            if (w_push && w_fifo_full)
                r_ovf <= 1'b1;
            if (w_count_wr) begin
                if (wbs_sel_i[0]) r_count[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) r_count[15:8] <= wbs_dat_i[15:8];
            end

            if (w_abort) begin
                r_state     <= S_IDLE;
                r_confclk   <= 1'b0;
                r_count     <= '0;
                r_width_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_state <= S_WAIT;
                            r_done  <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (w_fifo_empty) begin
                            r_starved <= 1'b1;
                        end else begin
                            r_cbitin    <= w_fifo_head;
                            r_width_cnt <= '0;
                            r_state     <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (r_width_cnt == LOW_LAST) begin
                            r_width_cnt <= '0;
                            r_confclk   <= 1'b1;
                            r_state     <= S_HIGH;
                        end else begin
                            r_width_cnt <= r_width_cnt + 8'd1;
                        end
                    end
                    default: begin
                        if (w_high_last) begin
                            r_confclk   <= 1'b0;
                            r_readback  <= cbitout_i;
                            r_count     <= r_count - 16'd1;
                            r_width_cnt <= '0;
                            if (r_count == 16'd1) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_width_cnt <= r_width_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign blk_reset_o = r_blk_reset;
    assign confclk_o   = r_confclk;
    assign cbitin_o    = r_cbitin;
    assign irq_o       = r_done & r_irq_en;

endmodule

// File: tb/tb_morphle_config_loader.sv
// Self-checking bench for morphle_config_loader: register table, hand-written
// strobe/abort/reset sequences and randomized loads against a queue model.
module tb_morphle_config_loader;

    localparam int LOW_CYC  = 2;
    localparam int HIGH_CYC = 2;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0, adr = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        blk_reset_o, confclk_o, irq_o;
    logic [15:0] cbitin_o;
    logic [15:0] cbitout_i = '0;

    always #5 clk = ~clk;

    morphle_config_loader #(
        .BLOCKWIDTH (16),
        .FIFO_DEPTH (DEPTH),
        .LOW_CYC    (LOW_CYC),
        .HIGH_CYC   (HIGH_CYC)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (wb_rst_ni),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_i),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .blk_reset_o (blk_reset_o),
        .confclk_o   (confclk_o),
        .cbitin_o    (cbitin_o),
        .cbitout_i   (cbitout_i),
        .irq_o       (irq_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO contents, sticky overflow, expected readback
    logic [15:0] exp_q[$];
    logic        m_ovf;
    logic [15:0] exp_rb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit busy, input bit done,
                                               input bit ovf, input bit starved);
        int lvl;
        lvl = exp_q.size();
        return {21'd0, 3'(lvl), 2'd0, starved, ovf, done, (lvl == 0), (lvl == DEPTH), busy};
    endfunction

    // cbitout source: changes only while confclk is low
    logic        cbo_rand  = 1'b0;
    logic [15:0] cbo_fixed = '0;
    always @(negedge clk) begin
        if (!confclk_o)
            cbitout_i = cbo_rand ? 16'($urandom) : cbo_fixed;
    end

    // Strobe monitor
    int          cyc_cnt = 0;
    int          mon_pulses = 0;
    int          stable_cnt = 0;
    int          high_cnt = 0;
    int          rise_cyc[$];
    logic        prev_cc = 1'b0;
    logic [15:0] prev_cbitin = '0;
    logic [15:0] pend_rb = '0;
    logic        abort_expected = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        if (confclk_o && !prev_cc) begin
            mon_pulses++;
            rise_cyc.push_back(cyc_cnt);
            check("setup_stable", 32'(stable_cnt >= LOW_CYC), 32'd1);
            if (exp_q.size() > 0) check("pulse_word", 32'(cbitin_o), 32'(exp_q.pop_front()));
            else check("pulse_unexpected", 32'd1, 32'd0);
            pend_rb  = cbitout_i;
            high_cnt = 1;
        end else if (confclk_o) begin
            high_cnt++;
            check("cbitin_hold_high", 32'(cbitin_o), 32'(prev_cbitin));
        end else if (prev_cc) begin
            if (!abort_expected) begin
                check("high_width", high_cnt, HIGH_CYC);
                exp_rb = pend_rb;
            end
            abort_expected = 1'b0;
        end
        if (!confclk_o)
            stable_cnt = (cbitin_o == prev_cbitin) ? stable_cnt + 1 : 1;
        prev_cc     = confclk_o;
        prev_cbitin = cbitin_o;
    end

    task automatic wb_xfer(input logic wr, input logic [1:0] rg, input logic [31:0] wd,
                           input logic [3:0] sl, output logic [31:0] rd);
        int waited;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = {28'd0, rg, 2'b00}; dat_i = wd; sel = sl;
        waited = 0;
        do begin
            @(posedge clk); #1; waited++;
        end while (!wbs_ack_o && waited < 4);
        check("wb_ack", 32'(wbs_ack_o), 32'd1);
        rd  = wbs_dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] rg, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, rg, wd, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [1:0] rg, output logic [31:0] rd);
        wb_xfer(1'b0, rg, 32'd0, 4'hF, rd);
    endtask

    task automatic read_check(input string name, input logic [1:0] rg, input logic [31:0] exp);
        logic [31:0] rd;
        wb_read(rg, rd);
        check(name, rd, exp);
    endtask

    task automatic push_word(input logic [15:0] w);
        wb_write(2'd2, {16'd0, w});
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int c;
        c = 0;
        while (mon_pulses < target && c < budget) begin
            @(posedge clk); #2; c++;
        end
        check("pulse_wait", 32'(mon_pulses >= target), 32'd1);
    endtask

    task automatic wait_confclk_high(input string name);
        int c;
        c = 0;
        while (!confclk_o && c < 60) begin
            @(posedge clk); #2; c++;
        end
        check(name, 32'(confclk_o), 32'd1);
    endtask

    task automatic do_reset();
        wb_rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wb_rst_ni = 1'b1;
        exp_q.delete();
        m_ovf  = 1'b0;
        exp_rb = '0;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  rg;
        logic [31:0] wd;
        logic [3:0]  sl;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[29];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        logic [15:0] rb_before;
        int base, n, k, p;
        bit starved_flag;

        // Register-level table: reset values, overflow, sel, blocked start, abort
        tbl[0]  = '{1'b0, 2'd1, 32'h0,        4'hF, 1'b1, 32'h004};
        tbl[1]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 32'h001};
        tbl[2]  = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 32'h000};
        tbl[3]  = '{1'b0, 2'd2, 32'h0,        4'hF, 1'b1, 32'h000};
        tbl[4]  = '{1'b1, 2'd0, 32'h00,       4'hF, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 2'd2, 32'h1111,     4'hF, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 2'd2, 32'h2222,     4'hF, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 2'd2, 32'h3333,     4'hF, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 2'd2, 32'h4444,     4'hF, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 2'd2, 32'h5555,     4'hF, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 2'd1, 32'h0,        4'hF, 1'b1, 32'h412};
        tbl[11] = '{1'b1, 2'd0, 32'h08,       4'hF, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 2'd1, 32'h0,        4'hF, 1'b1, 32'h402};
        tbl[13] = '{1'b1, 2'd3, 32'h3,        4'hF, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 32'h003};
        tbl[15] = '{1'b1, 2'd0, 32'h01,       4'hF, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 2'd0, 32'h03,       4'hF, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 2'd1, 32'h0,        4'hF, 1'b1, 32'h402};
        tbl[18] = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 32'h001};
        tbl[19] = '{1'b1, 2'd0, 32'h05,       4'hF, 1'b0, 32'h0};
        tbl[20] = '{1'b0, 2'd1, 32'h0,        4'hF, 1'b1, 32'h004};
        tbl[21] = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 32'h000};
        tbl[22] = '{1'b1, 2'd3, 32'hABCD,     4'h1, 1'b0, 32'h0};
        tbl[23] = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 32'h0CD};
        tbl[24] = '{1'b1, 2'd3, 32'hFFFF1234, 4'hF, 1'b0, 32'h0};
        tbl[25] = '{1'b0, 2'd3, 32'h0,        4'hF, 1'b1, 32'h1234};
        tbl[26] = '{1'b1, 2'd0, 32'h10,       4'h0, 1'b0, 32'h0};
        tbl[27] = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 32'h001};
        tbl[28] = '{1'b1, 2'd3, 32'h0,        4'hF, 1'b0, 32'h0};

        do_reset();
        check("reset_confclk", 32'(confclk_o), 32'd0);
        check("reset_cbitin", 32'(cbitin_o), 32'd0);
        check("reset_irq", 32'(irq_o), 32'd0);
        check("reset_blk_reset", 32'(blk_reset_o), 32'd1);
        for (int i = 0; i < 29; i++) begin
            wb_xfer(tbl[i].wr, tbl[i].rg, tbl[i].wd, tbl[i].sl, rd);
            if (tbl[i].chk) check($sformatf("tbl_%0d", i), rd, tbl[i].exp);
        end
        exp_q.delete();
        check("tbl_no_pulse", mon_pulses, 0);
        check("tbl_confclk_low", 32'(confclk_o), 32'd0);

        // Basic three-word load
        do_reset();
        cbo_rand = 1'b1;
        wb_write(2'd0, 32'h10);
        wb_write(2'd3, 32'd3);
        push_word(16'hA5A5);
        push_word(16'h5A5A);
        push_word(16'hFFFF);
        base = mon_pulses;
        rise_cyc.delete();
        wb_write(2'd0, 32'h12);
        wait_pulses(base + 3, 200);
        repeat (6) @(posedge clk);
        #2;
        check("load3_pulses", mon_pulses, base + 3);
        if (rise_cyc.size() >= 3) begin
            check("load3_period_a", rise_cyc[1] - rise_cyc[0], 1 + LOW_CYC + HIGH_CYC);
            check("load3_period_b", rise_cyc[2] - rise_cyc[1], 1 + LOW_CYC + HIGH_CYC);
        end else begin
            check("load3_rise_count", rise_cyc.size(), 3);
        end
        check("load3_confclk", 32'(confclk_o), 32'd0);
        check("load3_cbitin_hold", 32'(cbitin_o), 32'hFFFF);
        check("load3_irq", 32'(irq_o), 32'd1);
        read_check("load3_status", 2'd1, 32'h00C);
        read_check("load3_count", 2'd3, 32'd0);
        read_check("load3_readback", 2'd2, 32'(exp_rb));

        // Starvation, then resume; fixed cbitout values for readback
        cbo_rand  = 1'b0;
        cbo_fixed = 16'h1234;
        wb_write(2'd0, 32'h18);
        wb_write(2'd3, 32'd2);
        push_word(16'hBEEF);
        base = mon_pulses;
        wb_write(2'd0, 32'h12);
        wait_pulses(base + 1, 100);
        repeat (8) @(posedge clk);
        #2;
        check("starve_confclk", 32'(confclk_o), 32'd0);
        check("starve_irq", 32'(irq_o), 32'd0);
        read_check("starve_status", 2'd1, 32'h025);
        read_check("starve_count", 2'd3, 32'd1);
        read_check("starve_readback", 2'd2, 32'h1234);
        cbo_fixed = 16'h0F0F;
        push_word(16'h0001);
        wait_pulses(base + 2, 100);
        repeat (6) @(posedge clk);
        #2;
        check("resume_pulses", mon_pulses, base + 2);
        check("resume_irq", 32'(irq_o), 32'd1);
        check("resume_cbitin", 32'(cbitin_o), 32'h0001);
        read_check("resume_status", 2'd1, 32'h02C);
        read_check("resume_readback", 2'd2, 32'h0F0F);

        // Abort during HIGH
        wb_write(2'd0, 32'h18);
        wb_write(2'd3, 32'd2);
        push_word(16'h1357);
        push_word(16'h2468);
        wb_write(2'd0, 32'h12);
        wait_confclk_high("abort_reach_high");
        rb_before = exp_rb;
        abort_expected = 1'b1;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_i = 32'h14; sel = 4'hF;
        @(posedge clk); #1;
        check("abort_ack", 32'(wbs_ack_o), 32'd1);
        check("abort_confclk", 32'(confclk_o), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        exp_q.delete();
        read_check("abort_status", 2'd1, 32'h004);
        read_check("abort_count", 2'd3, 32'd0);
        read_check("abort_readback", 2'd2, 32'(rb_before));
        check("abort_irq", 32'(irq_o), 32'd0);

        // Reset during HIGH
        wb_write(2'd3, 32'd2);
        push_word(16'h7777);
        wb_write(2'd0, 32'h12);
        wait_confclk_high("rst_reach_high");
        abort_expected = 1'b1;
        @(negedge clk);
        wb_rst_ni = 1'b0;
        @(posedge clk); #1;
        check("rst_confclk", 32'(confclk_o), 32'd0);
        check("rst_blk_reset", 32'(blk_reset_o), 32'd1);
        @(negedge clk);
        wb_rst_ni = 1'b1;
        exp_q.delete();
        m_ovf  = 1'b0;
        exp_rb = '0;
        read_check("rst_status", 2'd1, 32'h004);
        read_check("rst_ctrl", 2'd0, 32'h001);
        read_check("rst_count", 2'd3, 32'd0);
        read_check("rst_readback", 2'd2, 32'd0);
        check("rst_cbitin", 32'(cbitin_o), 32'd0);

        // Randomized loads against the queue model
        do_reset();
        cbo_rand = 1'b1;
        wb_write(2'd0, 32'h10);
        for (int it = 0; it < 20; it++) begin
            wb_write(2'd0, 32'h18);
            m_ovf = 1'b0;
            starved_flag = 1'b0;
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) push_word(16'($urandom));
            n = $urandom_range(0, 5);
            wb_write(2'd3, 32'(n));
            p = (n < exp_q.size()) ? n : exp_q.size();
            base = mon_pulses;
            wb_write(2'd0, 32'h12);
            wait_pulses(base + p, 200);
            repeat (6) @(posedge clk);
            #2;
            check($sformatf("rnd%0d_pulses", it), mon_pulses, base + p);
            if (n > p) begin
                read_check($sformatf("rnd%0d_starve_status", it), 2'd1,
                           exp_status(1'b1, 1'b0, m_ovf, 1'b1));
                read_check($sformatf("rnd%0d_starve_count", it), 2'd3, 32'(n - p));
                for (int r = 0; r < n - p; r++) begin
                    push_word(16'($urandom));
                    wait_pulses(base + p + r + 1, 100);
                end
                repeat (6) @(posedge clk);
                #2;
                starved_flag = 1'b1;
            end
            check($sformatf("rnd%0d_irq", it), 32'(irq_o), 32'(n > 0));
            check($sformatf("rnd%0d_confclk", it), 32'(confclk_o), 32'd0);
            read_check($sformatf("rnd%0d_status", it), 2'd1,
                       exp_status(1'b0, n > 0, m_ovf, starved_flag));
            read_check($sformatf("rnd%0d_count", it), 2'd3, 32'd0);
            read_check($sformatf("rnd%0d_readback", it), 2'd2, 32'(exp_rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
